fafc_otw_driver: RTL

- Consumer end of the FAFC oscillator-tuning-word (OTW) interface. Takes the 9-bit binary OTW and load strobe from the FAFC SAR and applies the code to the DCO capacitor bank.
- Bank is segmented: upper 4 bits drive 15 unit thermometer cells, lower 5 bits drive binary cells, each as a differential P/N pair.
- Code changes are slew-limited to one thermometer cell per REF cycle so the DCO is never kicked by a full-scale step. A settle counter then reports when the bank is stable.
- Sits between FAFC and the DCO bank decoder, in the REF domain.

---
 rtl/fafc_otw_driver_pkg.sv | 16 +
 rtl/fafc_otw_driver_therm_dec.sv | 14 +
 rtl/fafc_otw_driver.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fafc_otw_driver_pkg.sv
// Shared constants and state encoding for the FAFC oscillator-tuning-word driver.
package fafc_otw_driver_pkg;
   localparam int TH_BITS  = 4;
   localparam int BIN_BITS = 5;
   localparam int OTW_L    = TH_BITS + BIN_BITS;

   localparam logic [OTW_L-1:0] OTW_MID   = 9'd256;
   localparam logic [OTW_L-1:0] SLEW_STEP = 9'd32;

   typedef enum logic [1:0] {
      IDLE,
      SLEW,
      SETTLE,
      HOLD
   } otw_state_t;
endpackage

// File: rtl/fafc_otw_driver_therm_dec.sv
// Combinational binary-to-thermometer decoder for the unit capacitor cells.
module otw_therm_dec #(
   parameter int TH_BITS = fafc_otw_driver_pkg::TH_BITS
) (
   input  logic [TH_BITS-1:0]        i_code,
   output logic [(1<<TH_BITS)-2:0]   o_therm
);
   genvar gi;
   generate
      for (gi = 0; gi < (1 << TH_BITS) - 1; gi++) begin : g_cell
         assign o_therm[gi] = (i_code > TH_BITS'(gi));
      end
   endgenerate
endmodule

// File: rtl/fafc_otw_driver.sv
// Applies the FAFC tuning word to the segmented DCO capacitor bank, slewing
// one thermometer cell per REF cycle and reporting when the bank has settled.
module fafc_otw_driver #(
   parameter int TH_BITS  = fafc_otw_driver_pkg::TH_BITS,
   parameter int BIN_BITS = fafc_otw_driver_pkg::BIN_BITS,
   parameter int SETTLE_W = 5
) (
   input  logic                         REF,
   input  logic                         SPI_ARST,
   input  logic                         SPI_OTWDRV_EN,
   input  logic [TH_BITS+BIN_BITS-1:0]  OTW_IN,
   input  logic                         OTW_LOAD,
   input  logic                         FREQLOCK,
   input  logic [SETTLE_W-1:0]          SPI_SETTLE_CYC,
   output logic [(1<<TH_BITS)-2:0]      CAPTH_P,
   output logic [(1<<TH_BITS)-2:0]      CAPTH_N,
   output logic [BIN_BITS-1:0]          CAPBIN_P,
   output logic [BIN_BITS-1:0]          CAPBIN_N,
   output logic [TH_BITS+BIN_BITS-1:0]  OTW_APPLIED,
   output logic                         OTW_BUSY,
   output logic                         OTW_SETTLED
);
   import fafc_otw_driver_pkg::*;

   localparam int L_W     = TH_BITS + BIN_BITS;
   localparam int L_CELLS = (1 << TH_BITS) - 1;
   localparam logic [L_W-1:0]        L_MID    = L_W'(OTW_MID);
   localparam logic [L_W-1:0]        L_STEP   = L_W'(SLEW_STEP);
   localparam logic signed [L_W:0]   L_STEP_S = $signed({1'b0, L_STEP});
   localparam logic [L_CELLS-1:0]    L_TH_MID = L_CELLS'((1 << (1 << (TH_BITS - 1))) - 1);

   otw_state_t          r_state;
   otw_state_t          w_state_next;
   logic [L_W-1:0]      r_applied;
   logic [L_W-1:0]      r_target;
   logic [L_W-1:0]      w_applied_next;
   logic [L_W-1:0]      w_target_next;
   logic [SETTLE_W-1:0] r_cnt;
   logic [SETTLE_W-1:0] w_cnt_next;
   logic signed [L_W:0] w_d;
   logic                w_close;
   logic                w_load;
   logic [L_CELLS-1:0]  w_therm;

   assign w_load  = OTW_LOAD & ~FREQLOCK;
   // One extra bit keeps the difference signed over the full code range.
   assign w_d     = $signed({1'b0, r_target}) - $signed({1'b0, r_applied});
   assign w_close = (w_d <= L_STEP_S) && (w_d >= -L_STEP_S);

   always_comb begin
      w_applied_next = r_applied;
      w_target_next  = r_target;
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      if (!SPI_OTWDRV_EN) begin
         w_applied_next = L_MID;
         w_target_next  = L_MID;
         w_state_next   = IDLE;
         w_cnt_next     = '0;
      end else if (w_load) begin
         // Capture edge leaves the bank alone; stepping resumes from applied.
         w_target_next = OTW_IN;
         w_state_next  = SLEW;
         w_cnt_next    = '0;
      end else begin
         case (r_state)
            SLEW: begin
               if (w_close) begin
                  w_applied_next = r_target;
                  w_state_next   = SETTLE;
                  w_cnt_next     = SPI_SETTLE_CYC;
               end else if (w_d[L_W]) begin
                  w_applied_next = r_applied - L_STEP;
               end else begin
                  w_applied_next = r_applied + L_STEP;
               end
            end
            SETTLE: begin
               if (r_cnt != '0) begin
                  w_cnt_next = r_cnt - SETTLE_W'(1);
               end else begin
                  w_state_next = HOLD;
               end
            end
            default: ;
         endcase
      end
   end

   otw_therm_dec #(.TH_BITS(TH_BITS)) u_therm (
      .i_code  (w_applied_next[L_W-1:BIN_BITS]),
      .o_therm (w_therm)
   );

   always_ff @(posedge REF or posedge SPI_ARST) begin
      if (SPI_ARST) begin
         r_applied   <= L_MID;
         r_target    <= L_MID;
         r_state     <= IDLE;
         r_cnt       <= '0;
         CAPTH_P     <= L_TH_MID;
         CAPTH_N     <= ~L_TH_MID;
         CAPBIN_P    <= L_MID[BIN_BITS-1:0];
         CAPBIN_N    <= ~L_MID[BIN_BITS-1:0];
         OTW_BUSY    <= 1'b0;
         OTW_SETTLED <= 1'b0;
      end else begin
         r_applied   <= w_applied_next;
         r_target    <= w_target_next;
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         CAPTH_P     <= w_therm;
         CAPTH_N     <= ~w_therm;
         CAPBIN_P    <= w_applied_next[BIN_BITS-1:0];
         CAPBIN_N    <= ~w_applied_next[BIN_BITS-1:0];
         OTW_BUSY    <= (w_state_next == SLEW) || (w_state_next == SETTLE);
         OTW_SETTLED <= (w_state_next == HOLD);
      end
   end

   assign OTW_APPLIED = r_applied;
endmodule
